// File: rtl/id_ex_pipeline_register.sv
// id_ex_pipeline_register
// ID/EX pipeline register of the 5-stage MIPS datapath. It registers the
// decoded control, register read data, immediate and register addresses from
// ID and presents them to EX one cycle later. Bubbles come from the hazard
// unit (contral_all_0) or from a taken branch (flush), and hold freezes the
// stage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   contral_all_0       load-use bubble request from the hazard unit
//   flush               branch-taken flush from EX
//   hold                global freeze; contents are kept
//   *_1_to_2            ID-side fields: valid, PC+4, Rs/Rt data, immediate,
//                       Rs/Rt/Rd/shamt, funct, control bits, ALUOp
//   *_2_to_3            registered copies presented to EX
//   bubble_cnt, flush_cnt  saturating event counters, present only when the
//                       ID_EX_STALL_CNT_EN macro is defined
//
// Update priority on each edge: rst > flush > hold > contral_all_0 > capture.
module id_ex_pipeline_register #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              contral_all_0,
  input  logic              flush,
  input  logic              hold,
  input  logic              valid_1_to_2,
  input  logic [DATA_W-1:0] PC4_1_to_2,
  input  logic [DATA_W-1:0] RsData_1_to_2,
  input  logic [DATA_W-1:0] RtData_1_to_2,
  input  logic [DATA_W-1:0] Imm_1_to_2,
  input  logic [REG_AW-1:0] RsAddr_1_to_2,
  input  logic [REG_AW-1:0] RtAddr_1_to_2,
  input  logic [REG_AW-1:0] RdAddr_1_to_2,
  input  logic [REG_AW-1:0] Shamt_1_to_2,
  input  logic [5:0]        Funct_1_to_2,
  input  logic              RegWrite_1_to_2,
  input  logic              MemtoReg_1_to_2,
  input  logic              Mem_r_1_to_2,
  input  logic              Mem_w_1_to_2,
  input  logic              Branch_1_to_2,
  input  logic              ALUSrc_1_to_2,
  input  logic              RegDst_1_to_2,
  input  logic [1:0]        ALUOp_1_to_2,
  output logic              valid_2_to_3,
  output logic [DATA_W-1:0] PC4_2_to_3,
  output logic [DATA_W-1:0] RsData_2_to_3,
  output logic [DATA_W-1:0] RtData_2_to_3,
  output logic [DATA_W-1:0] Imm_2_to_3,
  output logic [REG_AW-1:0] RsAddr_2_to_3,
  output logic [REG_AW-1:0] RtAddr_2_to_3,
  output logic [REG_AW-1:0] RdAddr_2_to_3,
  output logic [REG_AW-1:0] Shamt_2_to_3,
  output logic [5:0]        Funct_2_to_3,
  output logic              RegWrite_2_to_3,
  output logic              MemtoReg_2_to_3,
  output logic              Mem_r_2_to_3,
  output logic              Mem_w_2_to_3,
  output logic              Branch_2_to_3,
  output logic              ALUSrc_2_to_3,
  output logic              RegDst_2_to_3,
`ifdef ID_EX_STALL_CNT_EN
  output logic [1:0]        ALUOp_2_to_3,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt
`else
  output logic [1:0]        ALUOp_2_to_3
`endif
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] shamt;
    logic [5:0]        funct;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_r;
    logic              mem_w;
    logic              branch;
    logic              alu_src;
    logic              reg_dst;
    logic [1:0]        alu_op;
  } stage_t;

  stage_t in_s;
  stage_t stage_d, stage_q;

  always_comb begin
    in_s            = '0;
    in_s.valid      = valid_1_to_2;
    in_s.pc4        = PC4_1_to_2;
    in_s.rs_data    = RsData_1_to_2;
    in_s.rt_data    = RtData_1_to_2;
    in_s.imm        = Imm_1_to_2;
    in_s.rs_addr    = RsAddr_1_to_2;
    in_s.rt_addr    = RtAddr_1_to_2;
    in_s.rd_addr    = RdAddr_1_to_2;
    in_s.shamt      = Shamt_1_to_2;
    in_s.funct      = Funct_1_to_2;
    in_s.alu_op     = ALUOp_1_to_2;
    // A non-instruction must never carry live control into EX.
    if (valid_1_to_2) begin
      in_s.reg_write  = RegWrite_1_to_2;
      in_s.mem_to_reg = MemtoReg_1_to_2;
      in_s.mem_r      = Mem_r_1_to_2;
      in_s.mem_w      = Mem_w_1_to_2;
      in_s.branch     = Branch_1_to_2;
      in_s.alu_src    = ALUSrc_1_to_2;
      in_s.reg_dst    = RegDst_1_to_2;
    end
  end

  // flush beats hold so a taken branch is not lost during a freeze; a bubble
  // request under hold is dropped because the hazard unit re-asserts it.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (hold) begin
      stage_d = stage_q;
    end else if (contral_all_0) begin
      stage_d = '0;
    end else begin
      stage_d = in_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_2_to_3    = stage_q.valid;
  assign PC4_2_to_3      = stage_q.pc4;
  assign RsData_2_to_3   = stage_q.rs_data;
  assign RtData_2_to_3   = stage_q.rt_data;
  assign Imm_2_to_3      = stage_q.imm;
  assign RsAddr_2_to_3   = stage_q.rs_addr;
  assign RtAddr_2_to_3   = stage_q.rt_addr;
  assign RdAddr_2_to_3   = stage_q.rd_addr;
  assign Shamt_2_to_3    = stage_q.shamt;
  assign Funct_2_to_3    = stage_q.funct;
  assign RegWrite_2_to_3 = stage_q.reg_write;
  assign MemtoReg_2_to_3 = stage_q.mem_to_reg;
  assign Mem_r_2_to_3    = stage_q.mem_r;
  assign Mem_w_2_to_3    = stage_q.mem_w;
  assign Branch_2_to_3   = stage_q.branch;
  assign ALUSrc_2_to_3   = stage_q.alu_src;
  assign RegDst_2_to_3   = stage_q.reg_dst;
  assign ALUOp_2_to_3    = stage_q.alu_op;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (flush) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (!hold && contral_all_0) begin
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_r;
    logic        mem_w;
    logic        branch;
    logic        alu_src;
    logic        reg_dst;
    logic [1:0]  alu_op;
  } fields_t;

  typedef struct packed {
    logic    rst;
    logic    flush;
    logic    hold;
    logic    bub;
    fields_t f;
  } stim_t;

  typedef struct packed {
    fields_t     f;
    logic [31:0] bcnt;
    logic [31:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, contral_all_0, flush, hold;
  fields_t drv;
  fields_t act;
  logic [31:0] bubble_cnt_w, flush_cnt_w;

  logic        valid_o, RegWrite_o, MemtoReg_o, Mem_r_o, Mem_w_o, Branch_o, ALUSrc_o, RegDst_o;
  logic [31:0] PC4_o, RsData_o, RtData_o, Imm_o;
  logic [4:0]  RsAddr_o, RtAddr_o, RdAddr_o, Shamt_o;
  logic [5:0]  Funct_o;
  logic [1:0]  ALUOp_o;

  id_ex_pipeline_register #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .contral_all_0(contral_all_0), .flush(flush), .hold(hold),
    .valid_1_to_2(drv.valid), .PC4_1_to_2(drv.pc4), .RsData_1_to_2(drv.rs_data),
    .RtData_1_to_2(drv.rt_data), .Imm_1_to_2(drv.imm), .RsAddr_1_to_2(drv.rs_addr),
    .RtAddr_1_to_2(drv.rt_addr), .RdAddr_1_to_2(drv.rd_addr), .Shamt_1_to_2(drv.shamt),
    .Funct_1_to_2(drv.funct), .RegWrite_1_to_2(drv.reg_write), .MemtoReg_1_to_2(drv.mem_to_reg),
    .Mem_r_1_to_2(drv.mem_r), .Mem_w_1_to_2(drv.mem_w), .Branch_1_to_2(drv.branch),
    .ALUSrc_1_to_2(drv.alu_src), .RegDst_1_to_2(drv.reg_dst), .ALUOp_1_to_2(drv.alu_op),
    .valid_2_to_3(valid_o), .PC4_2_to_3(PC4_o), .RsData_2_to_3(RsData_o),
    .RtData_2_to_3(RtData_o), .Imm_2_to_3(Imm_o), .RsAddr_2_to_3(RsAddr_o),
    .RtAddr_2_to_3(RtAddr_o), .RdAddr_2_to_3(RdAddr_o), .Shamt_2_to_3(Shamt_o),
    .Funct_2_to_3(Funct_o), .RegWrite_2_to_3(RegWrite_o), .MemtoReg_2_to_3(MemtoReg_o),
    .Mem_r_2_to_3(Mem_r_o), .Mem_w_2_to_3(Mem_w_o), .Branch_2_to_3(Branch_o),
    .ALUSrc_2_to_3(ALUSrc_o), .RegDst_2_to_3(RegDst_o),
`ifdef ID_EX_STALL_CNT_EN
    .ALUOp_2_to_3(ALUOp_o), .bubble_cnt(bubble_cnt_w), .flush_cnt(flush_cnt_w)
`else
    .ALUOp_2_to_3(ALUOp_o)
`endif
  );

`ifndef ID_EX_STALL_CNT_EN
  assign bubble_cnt_w = '0;
  assign flush_cnt_w  = '0;
`endif

  assign act = {valid_o, PC4_o, RsData_o, RtData_o, Imm_o, RsAddr_o, RtAddr_o, RdAddr_o,
                Shamt_o, Funct_o, RegWrite_o, MemtoReg_o, Mem_r_o, Mem_w_o, Branch_o,
                ALUSrc_o, RegDst_o, ALUOp_o};

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  // Reference state: what EX should see, plus event counts.
  fields_t     m_out  = '0;
  logic [31:0] m_bcnt = '0;
  logic [31:0] m_fcnt = '0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: the stage presents a new output each edge; compare against the
  // expectation queued for that edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid", 256'(act.valid), 256'(e.f.valid));
        check("ctrl", 256'({act.reg_write, act.mem_r, act.mem_w, act.branch}),
              256'({e.f.reg_write, e.f.mem_r, e.f.mem_w, e.f.branch}));
        check("all_fields", 256'(act), 256'(e.f));
`ifdef ID_EX_STALL_CNT_EN
        check("bubble_cnt", 256'(bubble_cnt_w), 256'(e.bcnt));
        check("flush_cnt", 256'(flush_cnt_w), 256'(e.fcnt));
`endif
      end
    end
  end

  function automatic fields_t rand_fields();
    fields_t f;
    f.valid      = ($urandom_range(0, 3) != 0);
    f.pc4        = $urandom;
    f.rs_data    = $urandom;
    f.rt_data    = $urandom;
    f.imm        = $urandom;
    f.rs_addr    = 5'($urandom);
    f.rt_addr    = 5'($urandom);
    f.rd_addr    = 5'($urandom);
    f.shamt      = 5'($urandom);
    f.funct      = 6'($urandom);
    f.reg_write  = 1'($urandom);
    f.mem_to_reg = 1'($urandom);
    f.mem_r      = 1'($urandom);
    f.mem_w      = 1'($urandom);
    f.branch     = 1'($urandom);
    f.alu_src    = 1'($urandom);
    f.reg_dst    = 1'($urandom);
    f.alu_op     = 2'($urandom);
    return f;
  endfunction

  // One cycle of stimulus: drive at the falling edge, predict the next edge.
  task automatic step(input stim_t s);
    exp_t e;
    fields_t cap;
    @(negedge clk);
    rst = s.rst; flush = s.flush; hold = s.hold; contral_all_0 = s.bub; drv = s.f;
    cap = s.f;
    if (!cap.valid) begin
      cap.reg_write = 0; cap.mem_to_reg = 0; cap.mem_r = 0; cap.mem_w = 0;
      cap.branch = 0; cap.alu_src = 0; cap.reg_dst = 0;
    end
    if (s.rst) begin
      m_out = '0; m_bcnt = 0; m_fcnt = 0;
    end else if (s.flush) begin
      m_out = '0;
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
    end else if (s.hold) begin
      m_out = m_out;
    end else if (s.bub) begin
      m_out = '0;
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
    end else begin
      m_out = cap;
    end
    e.f = m_out; e.bcnt = m_bcnt; e.fcnt = m_fcnt;
    exp_q.push_back(e);
  endtask

  stim_t s;
  fields_t lw_f, add_f;

  initial begin
    rst = 1; flush = 0; hold = 0; contral_all_0 = 0; drv = '0;

    // Reset with every input at 1.
    s = '1;
    step(s);
    step(s);
    // Release: first edge with rst=0 captures.
    s = '0; s.f = rand_fields(); s.f.valid = 1;
    step(s);

    // Normal flow.
    s = '0; s.f = rand_fields(); s.f.valid = 1; s.f.rt_addr = 5; s.f.mem_r = 1;
    s.f.rs_data = 32'h1234_5678;
    step(s);

    // Load-use: lw $5, then add $x,$5 bubbles once, then add appears.
    lw_f = rand_fields(); lw_f.valid = 1; lw_f.mem_r = 1; lw_f.reg_write = 1;
    lw_f.mem_to_reg = 1; lw_f.rt_addr = 5;
    add_f = rand_fields(); add_f.valid = 1; add_f.mem_r = 0; add_f.mem_w = 0;
    add_f.reg_write = 1; add_f.rs_addr = 5;
    s = '0; s.f = lw_f; step(s);
    s = '0; s.f = add_f; s.bub = 1; step(s);
    s = '0; s.f = add_f; step(s);

    // Hold three cycles with changing inputs and a pending bubble request.
    for (int i = 0; i < 3; i++) begin
      s = '0; s.hold = 1; s.bub = 1; s.f = rand_fields(); step(s);
    end

    // flush wins over hold.
    s = '0; s.hold = 1; s.flush = 1; s.f = rand_fields(); s.f.valid = 1; s.f.reg_write = 1;
    step(s);

    // Invalid instruction with live control bits.
    s = '0; s.f = rand_fields(); s.f.valid = 0; s.f.reg_write = 1; s.f.mem_w = 1;
    s.f.mem_r = 1; s.f.branch = 1; step(s);

    // flush and bubble request together: one bubble, counted as flush.
    s = '0; s.f = rand_fields(); s.f.valid = 1; step(s);
    s = '0; s.flush = 1; s.bub = 1; s.f = rand_fields(); step(s);

    // Reset mid-stream, then capture on the first edge without rst.
    s = '0; s.f = rand_fields(); s.f.valid = 1; step(s);
    s = '0; s.rst = 1; s.flush = 1; s.f = rand_fields(); step(s);
    s = '0; s.f = rand_fields(); s.f.valid = 1; step(s);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.f     = rand_fields();
      s.rst   = ($urandom_range(0, 49) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.hold  = ($urandom_range(0, 5) == 0);
      s.bub   = ($urandom_range(0, 4) == 0);
      step(s);
    end

`ifdef ID_EX_STALL_CNT_EN
    // Saturation: preload bubble_cnt near the top, then three bubbles.
    s = '0; s.f = rand_fields(); step(s);
    @(negedge clk);
    force dut.bubble_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt_q;
    m_bcnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      s = '0; s.bub = 1; s.f = rand_fields(); step(s);
    end
    s = '0; s.f = rand_fields(); step(s);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
